lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that sits between the execute stage and the data memory port. It accepts one RV32 load or store per transaction from the pipeline. It drives a word-addressed, byte-enabled req/ack memory interface, then returns sign- or zero-extended load data or a completion status. It owns alignment checking, lane steering and a bus watchdog, and the pipeline stalls on `req_ready_o`.

## Interface
- `TIMEOUT_CYC`, 16: number of ACCESS cycles without `mem_ack_i` before the watchdog aborts the beat (legal range 2..255).
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `req_valid_i` in 1: pipeline request valid.
- `req_ready_o` out 1: block idle and able to accept; a request is accepted when `req_valid_i & req_ready_o`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I size/sign code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, LSB-justified.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 32: extended load data; 0 for stores, errors, and whenever `rsp_valid_o` is 0.
- `rsp_err_o` out 1: qualified by `rsp_valid_o`; set for illegal funct3, misalignment, or timeout.
- `mem_req_o` out 1: memory beat request; held until ack.
- `mem_we_o` out 1: beat is a write.
- `mem_addr_o` out 32: word address, bits [1:0] always 00.
- `mem_be_o` out 4: byte lane enables.
- `mem_wdata_o` out 32: lane-shifted store data.
- `mem_ack_i` in 1: beat complete; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in 32: read word.

## Operation
- States: IDLE, ACCESS, ACCESS2 (only with the macro), RESP.
- Reset values: all `mem_*` outputs are 0, `rsp_valid_o` = 0, `rsp_err_o` = 0, `rsp_rdata_o` = 0. `req_ready_o` = 1 (state IDLE).
- IDLE, on accept: the request is latched.
  - If funct3 is illegal (011, 110, 111; or 1xx with `req_we_i` = 1), go to RESP with error and issue no beat.
  - Otherwise compute offset `o = addr[1:0]` and size `s` (1, 2 or 4 bytes).
  - Natural alignment means `o % s == 0`. A naturally aligned request goes to ACCESS.
- ACCESS: `mem_req_o` = 1 with the address, BE and wdata stable.
  - BE = ((1<<s)-1) << o, truncated to 4 bits.
  - wdata = `req_wdata_i << 8*o`.
- On `mem_ack_i` with a load: rdata is extracted as `mem_rdata_i >> 8*o`, masked to s bytes, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
- After the final beat's ack, go to RESP.
- Watchdog: the counter clears on entry to each beat and increments each cycle the beat is un-acked.
  - When it reaches `TIMEOUT_CYC`, drop `mem_req_o` and go to RESP with error.
  - An ack arriving in that same cycle wins over the timeout.
- RESP: `rsp_valid_o` = 1 for one cycle, then IDLE. `req_ready_o` = 0 in every state except IDLE.
- Reset asserted mid-transaction: the in-flight beat is abandoned immediately and `mem_req_o` drops asynchronously. No response is issued.

## Timing
- Zero-wait memory (ack in the first ACCESS cycle): accept in cycle 0, `mem_req_o` in cycle 1, `rsp_valid_o` in cycle 2.
- Each memory wait cycle adds 1 cycle of latency.
- Error without a beat: `rsp_valid_o` in cycle 1.
- Timeout: `mem_req_o` stays high for exactly `TIMEOUT_CYC` cycles, then `rsp_valid_o` follows in the next cycle.
- Back-to-back: the next accept can happen in the cycle after RESP. Throughput is 1 transaction per 3 cycles.

## Configuration
- `LSU_SPLIT_MISALIGNED_EN` undefined: any non-naturally-aligned access goes to RESP with error and issues no beat.
- `LSU_SPLIT_MISALIGNED_EN` defined, case `o + s <= 4`: the access is performed in a single ACCESS beat using the same lane rules.
- `LSU_SPLIT_MISALIGNED_EN` defined, case `o + s > 4`: two beats.
  - ACCESS uses word `A`, BE upper lanes from o, and the low bytes of data.
  - ACCESS2 uses `A+4`, BE lanes 0..(o+s-5), and the remaining bytes.
  - For loads, the bytes from both beats are merged before extension.
- Split-access error: a timeout on either beat gives an error. If the first beat of a store completed before an error, it is not rolled back.

## Structure
- Shared package `lsu_pkg`: funct3 localparams (LB..LHU, SB..SW), state encoding, size decode function, BE generation function.
- One sub-module, `lsu_lane_align`, is combinational. It handles store shift/BE and load extract/extend, and is instanced once; ACCESS2 reuses it with an adjusted offset.

## Test plan
- SW 0xDEADBEEF to 0x10, zero-wait memory: `mem_addr_o` = 0x10, BE = 1111, wdata = 0xDEADBEEF, `rsp_valid_o` in cycle 2, err = 0.
- LB from 0x13 with `mem_rdata_i` = 0x80xxxxxx: BE = 1000, rdata = 0xFFFFFF80. LBU from the same address returns 0x00000080.
- SH 0x1234 to 0x06: BE = 1100, wdata = 0x12340000. LHU from 0x06 with 3 wait cycles returns 0x00001234 with `rsp_valid_o` in cycle 5.
- LW from 0x02:
  - Macro off: err = 1 in cycle 1 and `mem_req_o` never asserted.
  - Macro on: beat 0x00 with BE = 1100, beat 0x04 with BE = 0011; rdata = {rd2[15:0], rd1[31:16]}.
- `mem_ack_i` held low with `TIMEOUT_CYC` = 16: `mem_req_o` high for exactly 16 cycles, then `rsp_valid_o` with err = 1; the next request is accepted normally.
- `reset_n` pulsed low during ACCESS: `mem_req_o` is 0 immediately, no `rsp_valid_o`, `req_ready_o` = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: funct3 codes, FSM state
// encoding and the size/byte-enable/legality helpers.
// Optional feature macro: LSU_SPLIT_MISALIGNED_EN (adds the ACCESS2 state).
package lsu_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

`ifdef LSU_SPLIT_MISALIGNED_EN
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StResp    = 2'd2,
    StAccess2 = 2'd3
  } lsu_state_e;
`else
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } lsu_state_e;
`endif

  // Access size in bytes (1, 2 or 4) from the low funct3 bits.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // ((1 << size) - 1) << off, truncated to four lanes.
  function automatic logic [3:0] gen_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask << off;
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return funct3 inside {F3Sb, F3Sh, F3Sw};
    end
    return funct3 inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu};
  endfunction

  function automatic logic naturally_aligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd2:    return ~off[0];
      3'd4:    return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data shift and byte enables, load byte
// extraction and sign/zero extension. With 'second' set it produces the lanes
// of the upper word of a split access and merges 'partial' from the first beat.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic        second,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] partial,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [2:0]  size;
  logic [3:0]  mask;
  logic [5:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] raw;

  // Shift lanes in or out of place, then extend the loaded value.
  always_comb begin
    size  = size_bytes(funct3);
    mask  = gen_be(size, 2'b00);
    sh_lo = {1'b0, off, 3'b000};
    sh_hi = 6'd32 - sh_lo;
    if (second) begin
      // Bytes that spilled past lane 3 land at the bottom of the next word.
      be         = mask >> (3'd4 - {1'b0, off});
      wdata_lane = wdata >> sh_hi;
      raw        = (rdata << sh_hi) | partial;
    end else begin
      be         = gen_be(size, off);
      wdata_lane = wdata << sh_lo;
      raw        = rdata >> sh_lo;
    end
    case (funct3)
      F3Lb:    rdata_ext = {{24{raw[7]}}, raw[7:0]};
      F3Lh:    rdata_ext = {{16{raw[15]}}, raw[15:0]};
      F3Lbu:   rdata_ext = {24'h0, raw[7:0]};
      F3Lhu:   rdata_ext = {16'h0, raw[15:0]};
      default: rdata_ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-addressed,
// byte-enabled req/ack memory port, with alignment checks and a bus watchdog.
// Optional feature macro: LSU_SPLIT_MISALIGNED_EN (misaligned accesses are
// performed in one or two beats instead of being rejected).
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  wd_cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic        in_idle;
  logic [1:0]  lane_off;
  logic [2:0]  lane_f3;
  logic [31:0] lane_wdata;
  logic        lane_second;
  logic [31:0] lane_partial;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata_sh;
  logic [31:0] lane_rdata;
  logic [2:0]  req_size;
  logic        req_legal;
  logic        timeout;

`ifdef LSU_SPLIT_MISALIGNED_EN
  logic        split_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] partial_q;
  logic        req_split;
`else
  logic        req_aligned;
`endif

  // Lane aligner sees the incoming request while idle, the latched one after.
  always_comb begin
    in_idle   = state_q == StIdle;
    lane_off  = in_idle ? req_addr_i[1:0] : off_q;
    lane_f3   = in_idle ? req_funct3_i : f3_q;
    req_size  = size_bytes(req_funct3_i);
    req_legal = funct3_legal(req_we_i, req_funct3_i);
    timeout   = wd_cnt_q == 8'(TIMEOUT_CYC - 1);
`ifdef LSU_SPLIT_MISALIGNED_EN
    lane_wdata   = in_idle ? req_wdata_i : wdata_q;
    // In the first beat of a split, precompute the second beat's lanes.
    lane_second  = split_q & ((state_q == StAccess) | (state_q == StAccess2));
    lane_partial = partial_q;
    req_split    = ({1'b0, req_addr_i[1:0]} + req_size) > 3'd4;
`else
    lane_wdata   = req_wdata_i;
    lane_second  = 1'b0;
    lane_partial = 32'h0;
    req_aligned  = naturally_aligned(req_size, req_addr_i[1:0]);
`endif
  end

  lsu_lane_align u_lane_align (
    .off        (lane_off),
    .second     (lane_second),
    .funct3     (lane_f3),
    .wdata      (lane_wdata),
    .rdata      (mem_rdata_i),
    .partial    (lane_partial),
    .be         (lane_be),
    .wdata_lane (lane_wdata_sh),
    .rdata_ext  (lane_rdata)
  );

  // Transaction FSM with registered pipeline and memory outputs.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      wd_cnt_q    <= 8'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
`ifdef LSU_SPLIT_MISALIGNED_EN
      split_q     <= 1'b0;
      word_q      <= 30'h0;
      wdata_q     <= 32'h0;
      partial_q   <= 32'h0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            f3_q        <= req_funct3_i;
            off_q       <= req_addr_i[1:0];
            req_ready_q <= 1'b0;
            wd_cnt_q    <= 8'h0;
`ifdef LSU_SPLIT_MISALIGNED_EN
            word_q      <= req_addr_i[31:2];
            wdata_q     <= req_wdata_i;
            split_q     <= req_split;
            if (!req_legal) begin
`else
            if (!req_legal || !req_aligned) begin
`endif
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              state_q     <= StResp;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_be_q    <= lane_be;
              mem_wdata_q <= lane_wdata_sh;
              state_q     <= StAccess;
            end
          end
        end
        StAccess: begin
          if (mem_ack_i) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
            if (split_q) begin
              partial_q   <= mem_rdata_i >> {off_q, 3'b000};
              mem_addr_q  <= {word_q + 30'd1, 2'b00};
              mem_be_q    <= lane_be;
              mem_wdata_q <= lane_wdata_sh;
              wd_cnt_q    <= 8'h0;
              state_q     <= StAccess2;
            end else begin
              mem_req_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= we_q ? 32'h0 : lane_rdata;
              state_q     <= StResp;
            end
`else
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? 32'h0 : lane_rdata;
            state_q     <= StResp;
`endif
          end else if (timeout) begin
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
`ifdef LSU_SPLIT_MISALIGNED_EN
        StAccess2: begin
          if (mem_ack_i) begin
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? 32'h0 : lane_rdata;
            state_q     <= StResp;
          end else if (timeout) begin
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
`endif
        StResp: begin
          // Beat request already dropped; park the remaining bus outputs.
          mem_we_q    <= 1'b0;
          mem_addr_q  <= 32'h0;
          mem_be_q    <= 4'h0;
          mem_wdata_q <= 32'h0;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: stimulus pushes expected responses,
// a monitor pops and compares on every rsp_valid_o.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  lsu_mem_master #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i        (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Response monitor: every completion must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, expected no response",
                 rsp_err, rsp_rdata);
      end else begin
        e = sb.pop_front();
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_cycle", cyc, e.cyc);
      end
    end else begin
      check("rsp_rdata_idle", rsp_rdata, 32'h0);
    end
  end

  task automatic push(input logic err, input logic [31:0] rdata, input int unsigned at);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  // Present one request; returns the cycle count of the accept cycle (cycle 0).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int unsigned c0);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    c0         = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Serve one memory beat after 'waits' un-acked cycles.
  task automatic serve_beat(input logic [31:0] ea, input logic [3:0] ebe, input logic ewe,
                            input logic [31:0] ewd, input int waits, input logic [31:0] rd);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      check("mem_req", {31'h0, mem_req}, 32'h1);
      if (w == 0) begin
        check("mem_addr", mem_addr, ea);
        check("mem_be", {28'h0, mem_be}, {28'h0, ebe});
        check("mem_we", {31'h0, mem_we}, {31'h0, ewe});
        if (ewe) check("mem_wdata", mem_wdata, ewd);
      end
      if (w == waits) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int waits, input logic [31:0] rd,
                     input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                     output int unsigned c0);
    logic [31:0] wa;
    issue(we, f3, a, wd, c0);
    push(1'b0, erd, c0 + 2 + waits);
    wa = {a[31:2], 2'b00};
    serve_beat(wa, ebe, we, ewd, waits, rd);
  endtask

  task automatic txn_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned c0;
    issue(we, f3, a, 32'h0, c0);
    push(1'b1, 32'h0, c0 + 1);
    @(negedge clk);
    check("no_beat", {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    int unsigned c1;
    int unsigned hi;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    reset_n = 1'b1;

    // Aligned store, then back-to-back byte loads (sign and zero extension).
    txn(1'b1, F3Sw, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0, c0);
    txn(1'b0, F3Lb, 32'h13, 32'h0, 0, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80, c1);
    check("back_to_back_accept", c1 - c0, 32'd3);
    txn(1'b0, F3Lbu, 32'h13, 32'h0, 0, 32'h80123456, 4'b1000, 32'h0, 32'h00000080, c0);

    // Halfword store/loads, with memory wait states.
    txn(1'b1, F3Sh, 32'h06, 32'hABCD1234, 0, 32'h0, 4'b1100, 32'h12340000, 32'h0, c0);
    txn(1'b0, F3Lhu, 32'h06, 32'h0, 3, 32'h12345678, 4'b1100, 32'h0, 32'h00001234, c0);
    txn(1'b0, F3Lh, 32'h02, 32'h0, 1, 32'hF00D0000, 4'b1100, 32'h0, 32'hFFFFF00D, c0);
    txn(1'b1, F3Sb, 32'h0D, 32'h123456A5, 1, 32'h0, 4'b0010, 32'h3456A500, 32'h0, c0);

    // Illegal funct3 for load and store.
    txn_err(1'b0, 3'b011, 32'h40);
    txn_err(1'b1, 3'b100, 32'h40);

`ifdef LSU_SPLIT_MISALIGNED_EN
    issue(1'b0, F3Lw, 32'h02, 32'h0, c0);
    push(1'b0, 32'h66554433, c0 + 3);
    serve_beat(32'h0, 4'b1100, 1'b0, 32'h0, 0, 32'h44332211);
    serve_beat(32'h4, 4'b0011, 1'b0, 32'h0, 0, 32'h88776655);
    txn(1'b0, F3Lh, 32'h01, 32'h0, 0, 32'h00ABCD00, 4'b0110, 32'h0, 32'hFFFFABCD, c0);
`else
    txn_err(1'b0, F3Lw, 32'h02);
    txn_err(1'b0, F3Lh, 32'h01);
`endif

    // Watchdog: no ack at all.
    issue(1'b0, F3Lw, 32'h40, 32'h0, c0);
    push(1'b1, 32'h0, c0 + 17);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req) hi++;
      else if (hi > 0) break;
    end
    check("timeout_req_cycles", hi, 32'd16);
    txn(1'b0, F3Lw, 32'h40, 32'h0, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, c0);

    // Reset in the middle of a beat: abandoned, no response.
    issue(1'b0, F3Lw, 32'h20, 32'h0, c0);
    @(negedge clk);
    check("pre_reset_mem_req", {31'h0, mem_req}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_mem_req_drop", {31'h0, mem_req}, 32'h0);
    check("async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {31'h0, req_ready}, 32'h1);
    txn(1'b0, F3Lhu, 32'h22, 32'h0, 0, 32'hBEEF0000, 4'b1100, 32'h0, 32'h0000BEEF, c0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
